apb_initiator: RTL and testbench

- Single-outstanding APB3 initiator for the subsystem. Converts a valid/ready register-access request into an APB SETUP/ACCESS transfer and returns read data and an error status on a valid/ready response channel.
- Drives the APB responders in the subsystem, including the GPIO peripheral, from DV sequencers and small control engines that have no CPU attached.
- Has a bounded wait-state timeout, so a responder that never asserts pready cannot hang the requester.

---
 rtl/apb_initiator.sv | 176 +++++++++++++++++
 tb/tb_apb_initiator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB3 initiator.
// Accepts one register-access request at a time on a valid/ready channel, runs an APB
// SETUP/ACCESS transfer and returns read data plus error status on a valid/ready response
// channel. A bounded wait-state timeout keeps a silent responder from hanging the requester.
//
// Ports:
//   pclk_i, prstn_i         clock, asynchronous active-low reset
//   req_*                   request channel (valid/ready, addr, wdata, write)
//   rsp_*                   response channel (valid/ready, rdata, err, timeout)
//   psel_o .. pslverr_i     APB3 initiator interface
//   busy_o                  high whenever a transfer is in flight or a response is pending
//   err_count_o             saturating count of error responses
module apb_initiator #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                pclk_i,
    input  logic                prstn_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,
    input  logic                req_write_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [31:0]         paddr_o,
    output logic [31:0]         pwdata_o,
    input  logic [31:0]         prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i,
    output logic                busy_o,
    output logic [ERRCNT_W-1:0] err_count_o
);

    // A zero timeout still needs a legal (unused) one-bit counter.
    localparam int unsigned WaitW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WaitW-1:0] WaitLast = (TIMEOUT_CYC == 0) ? '0 : WaitW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic [31:0]           paddr_q, paddr_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  busy_q, busy_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  timeout_hit;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt_q == WaitLast);

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        err_count_d   = err_count_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    paddr_d    = req_addr_i;
                    pwrite_d   = req_write_i;
                    pwdata_d   = req_write_i ? req_wdata_i : 32'h0;
                    wait_cnt_d = '0;
                    psel_d     = 1'b1;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                // pready wins over a timeout landing on the same cycle.
                if (pready_i) begin
                    rsp_rdata_d   = pwrite_q ? 32'h0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = StResp;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = StResp;
                end else if (TIMEOUT_CYC != 0) begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
        endcase

        // Count once per error response, on entry to RESP.
        if (state_q == StAccess && state_d == StResp && rsp_err_d && !(&err_count_q)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            state_q       <= StIdle;
            paddr_q       <= 32'h0;
            pwdata_q      <= 32'h0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            err_count_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            err_count_q   <= err_count_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign req_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign busy_o        = busy_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed self-checking bench for apb_initiator (TIMEOUT_CYC = 4).
module tb_apb_initiator;

    logic        clk = 1'b0;
    logic        prstn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr, busy;
    logic [31:0] paddr, pwdata, prdata;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int npen, lat;

    always #5 clk = ~clk;

    apb_initiator #(
        .TIMEOUT_CYC (4),
        .ERRCNT_W    (8)
    ) u_dut (
        .pclk_i        (clk),
        .prstn_i       (prstn),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_write_i   (req_write),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverr_i     (pslverr),
        .busy_o        (busy),
        .err_count_o   (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer: pready rises on ACCESS cycle number waits+1 (never if waits is large).
    // Leaves the bench sampling the first RESP cycle. lat counts edges from accept to rsp_valid.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                        input int waits, input logic [31:0] rd, input logic slverr,
                        output int n_pen, output int n_lat);
        req_addr  = addr;
        req_wdata = wdata;
        req_write = wr;
        req_valid = 1'b1;
        pready    = 1'b0;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
        n_pen     = 0;
        n_lat     = 1;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            // Junk on ignored inputs while not completing.
            pready  = 1'b0;
            pslverr = 1'b1;
            prdata  = 32'hFFFF_FFFF;
            chk("paddr_stable", paddr, addr);
            chk("pwrite_stable", pwrite, wr);
            chk("pwdata_stable", pwdata, wr ? wdata : 32'h0);
            if (penable) begin
                n_pen++;
                if (n_pen == waits + 1) begin
                    pready  = 1'b1;
                    prdata  = rd;
                    pslverr = slverr;
                end
            end
            step();
            n_lat++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("rsp_valid_seen", rsp_valid, 1);
        chk("psel_low_resp", psel, 0);
    endtask

    initial begin
        prstn     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_write = 1'b0;
        rsp_ready = 1'b1;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        prstn = 1'b1;
        step();

        // Zero-wait write, hand-stepped for exact cycle placement.
        req_addr  = 32'h04;
        req_wdata = 32'hA5A5_0001;
        req_write = 1'b1;
        req_valid = 1'b1;
        pready    = 1'b1;
        chk("w_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("w_t1_psel", psel, 1);
        chk("w_t1_penable", penable, 0);
        chk("w_t1_paddr", paddr, 32'h04);
        chk("w_t1_pwrite", pwrite, 1);
        chk("w_t1_pwdata", pwdata, 32'hA5A5_0001);
        chk("w_t1_busy", busy, 1);
        step();
        chk("w_t2_psel", psel, 1);
        chk("w_t2_penable", penable, 1);
        chk("w_t2_pwdata", pwdata, 32'hA5A5_0001);
        step();
        chk("w_t3_rsp_valid", rsp_valid, 1);
        chk("w_t3_rsp_err", rsp_err, 0);
        chk("w_t3_rsp_rdata", rsp_rdata, 0);
        chk("w_t3_psel", psel, 0);
        chk("w_t3_penable", penable, 0);
        chk("w_t3_pwdata", pwdata, 32'hA5A5_0001);
        chk("w_t3_req_ready", req_ready, 0);
        pready = 1'b0;
        step();
        chk("w_idle_rsp_valid", rsp_valid, 0);

        // Read with two wait states.
        xfer(32'h00, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, npen, lat);
        chk("r2w_penable_cycles", npen, 3);
        chk("r2w_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("r2w_err", rsp_err, 0);
        chk("r2w_pwdata", pwdata, 0);
        step();

        // Slave error on a read: data still returned.
        xfer(32'h08, 32'h0, 1'b0, 0, 32'h1234, 1'b1, npen, lat);
        chk("slverr_err", rsp_err, 1);
        chk("slverr_timeout", rsp_timeout, 0);
        chk("slverr_rdata", rsp_rdata, 32'h1234);
        chk("slverr_count", err_count, 1);
        chk("slverr_lat", lat, 3);
        step();

        // Timeout with pready stuck low.
        xfer(32'h0C, 32'h0, 1'b0, 99, 32'h0, 1'b0, npen, lat);
        chk("to_access_cycles", npen, 4);
        chk("to_err", rsp_err, 1);
        chk("to_timeout", rsp_timeout, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_count", err_count, 2);
        step();

        // pready on the final timeout cycle completes normally.
        xfer(32'h0C, 32'h0, 1'b0, 3, 32'h0BAD_F00D, 1'b0, npen, lat);
        chk("to_edge_access_cycles", npen, 4);
        chk("to_edge_timeout", rsp_timeout, 0);
        chk("to_edge_err", rsp_err, 0);
        chk("to_edge_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("to_edge_count", err_count, 2);
        step();

        // Response backpressure with a second request waiting.
        rsp_ready = 1'b0;
        xfer(32'h10, 32'h0, 1'b0, 0, 32'h55AA_0000, 1'b0, npen, lat);
        req_addr  = 32'h18;
        req_wdata = 32'h0000_0011;
        req_write = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h55AA_0000);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_psel", psel, 0);
            chk("bp_paddr_held", paddr, 32'h10);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_hs_rsp_valid", rsp_valid, 1);
        step();
        chk("bp_after_hs_rsp_valid", rsp_valid, 0);
        chk("bp_after_hs_req_ready", req_ready, 1);
        chk("bp_after_hs_psel", psel, 0);
        step();
        req_valid = 1'b0;
        pready    = 1'b1;
        chk("bp_2nd_psel", psel, 1);
        chk("bp_2nd_paddr", paddr, 32'h18);
        step();
        chk("bp_2nd_penable", penable, 1);
        step();
        chk("bp_2nd_rsp_valid", rsp_valid, 1);
        chk("bp_2nd_rdata", rsp_rdata, 0);
        pready = 1'b0;
        step();

        // Drive the error counter into saturation (2 errors so far, 299 more).
        for (int i = 0; i < 299; i++) begin
            xfer(32'h40, 32'h0, 1'b0, 0, 32'h1234, 1'b1, npen, lat);
            step();
        end
        chk("err_count_sat", err_count, 32'hFF);

        // Reset in the middle of ACCESS.
        req_addr  = 32'h20;
        req_write = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_rst_in_access", penable, 1);
        #2;
        prstn = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_err_count", err_count, 0);
        @(negedge clk);
        prstn = 1'b1;
        step();
        chk("post_rst_req_ready", req_ready, 1);
        pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_rsp", rsp_valid, 0);
            chk("post_rst_no_psel", psel, 0);
            step();
        end
        xfer(32'h30, 32'hCAFE_0002, 1'b1, 0, 32'h0, 1'b0, npen, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_err", rsp_err, 0);
        chk("post_rst_rdata", rsp_rdata, 0);
        step();
        chk("post_rst_idle", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
